// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit with architectural HI/LO.
//   Radix-2 shift-add multiply and restoring divide, one bit per cycle,
//   DATA_WIDTH cycles per op. MTHI/MTLO write HI/LO at once.
// Optional feature macro: MDU_SIGNED_EN (ops 100/101 become signed MULT/DIV;
//   when undefined they are ignored like the reserved codes).
// Ports:
//   i_CLK, i_RST (async, active-low)
//   i_Start, i_Op[2:0], i_SrcA, i_SrcB : op request
//   i_Flush  : abort the in-flight op (also blocks a same-cycle start)
//   o_Busy   : iteration in progress
//   o_Done   : one-cycle pulse after a MULT/DIV commit
//   o_HI, o_LO : committed HI/LO registers
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_Start,
  input  logic [2:0]            i_Op,
  input  logic [DATA_WIDTH-1:0] i_SrcA,
  input  logic [DATA_WIDTH-1:0] i_SrcB,
  input  logic                  i_Flush,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic [DATA_WIDTH-1:0] o_HI,
  output logic [DATA_WIDTH-1:0] o_LO
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   wa_q, wa_d;   // multiply: running high half; divide: partial remainder
  logic [W-1:0]   wb_q, wb_d;   // multiply: multiplier / low half; divide: dividend -> quotient
  logic [W-1:0]   wm_q, wm_d;   // multiplicand or divisor magnitude
  logic           div_q, div_d;
  logic           negq_q, negq_d; // negate product / quotient at commit
  logic           negr_q, negr_d; // negate remainder at commit
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic [W:0]     mul_sum, div_sh, div_diff;
  logic [W-1:0]   it_a, it_b, res_hi, res_lo, mag_a, mag_b;
  logic [2*W-1:0] prod;
  logic           nq_start, nr_start, accept;

  always_comb begin
    // One iteration of the current op, from the work registers.
    mul_sum  = {1'b0, wa_q} + (wb_q[0] ? {1'b0, wm_q} : '0);
    div_sh   = {wa_q, wb_q[W-1]};
    div_diff = div_sh - {1'b0, wm_q};
    if (div_q) begin
      // Restoring step: keep the subtraction only when it did not borrow.
      if (!div_diff[W]) begin
        it_a = div_diff[W-1:0];
        it_b = {wb_q[W-2:0], 1'b1};
      end else begin
        it_a = div_sh[W-1:0];
        it_b = {wb_q[W-2:0], 1'b0};
      end
    end else begin
      it_a = mul_sum[W:1];
      it_b = {mul_sum[0], wb_q[W-1:1]};
    end

    // Sign correction applied only to the value being committed.
    prod = {it_a, it_b};
    if (negq_q) prod = -prod;
    if (div_q) begin
      res_hi = negr_q ? -it_a : it_a;
      res_lo = negq_q ? -it_b : it_b;
    end else begin
      res_hi = prod[2*W-1:W];
      res_lo = prod[W-1:0];
    end

`ifdef MDU_SIGNED_EN
    // Magnitudes for signed ops; the most negative value maps to 2^(W-1).
    mag_a    = (i_Op[2] && i_SrcA[W-1]) ? -i_SrcA : i_SrcA;
    mag_b    = (i_Op[2] && i_SrcB[W-1]) ? -i_SrcB : i_SrcB;
    nq_start = i_Op[2] && (i_SrcA[W-1] ^ i_SrcB[W-1]);
    nr_start = i_Op[2] && i_SrcA[W-1];
`else
    mag_a    = i_SrcA;
    mag_b    = i_SrcB;
    nq_start = 1'b0;
    nr_start = 1'b0;
`endif

    accept = i_Start && !i_Flush;

    state_d = state_q;
    cnt_d   = cnt_q;
    wa_d    = wa_q;
    wb_d    = wb_q;
    wm_d    = wm_q;
    div_d   = div_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      S_RUN: begin
        if (i_Flush) begin
          state_d = S_IDLE;
        end else begin
          wa_d  = it_a;
          wb_d  = it_b;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            hi_d    = res_hi;
            lo_d    = res_lo;
            state_d = S_DONE;
          end
        end
      end
      default: begin // S_IDLE and S_DONE accept ops identically
        state_d = S_IDLE;
        if (accept) begin
          case (i_Op)
            3'b010: hi_d = i_SrcA;
            3'b011: lo_d = i_SrcA;
`ifdef MDU_SIGNED_EN
            3'b000, 3'b001, 3'b100, 3'b101: begin
`else
            3'b000, 3'b001: begin
`endif
              if (i_Op[0] && i_SrcB == '0) begin
                // Divide by zero skips iteration entirely.
                hi_d    = i_SrcA;
                lo_d    = '1;
                state_d = S_DONE;
              end else begin
                wa_d    = '0;
                wb_d    = mag_a;
                wm_d    = mag_b;
                div_d   = i_Op[0];
                negq_d  = nq_start;
                negr_d  = nr_start;
                cnt_d   = CW'(DATA_WIDTH);
                state_d = S_RUN;
              end
            end
            default: ; // reserved: ignored
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wa_q    <= '0;
      wb_q    <= '0;
      wm_q    <= '0;
      div_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wa_q    <= wa_d;
      wb_q    <= wb_d;
      wm_q    <= wm_d;
      div_q   <= div_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign o_Busy = (state_q == S_RUN);
  assign o_Done = (state_q == S_DONE);
  assign o_HI   = hi_q;
  assign o_LO   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (DATA_WIDTH=32): directed cases plus
// randomized ops against an arithmetic reference model of HI/LO.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         start = 1'b0, flush = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] src_a = '0, src_b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_chk = 0, n_err = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;

  mult_div_unit #(.DATA_WIDTH(W)) dut (
    .i_CLK(clk), .i_RST(rst_n), .i_Start(start), .i_Op(op),
    .i_SrcA(src_a), .i_SrcB(src_b), .i_Flush(flush),
    .o_Busy(busy), .o_Done(done), .o_HI(hi), .o_LO(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference result {HI,LO} straight from integer arithmetic.
  function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: p = {32'd0, a} * {32'd0, b};
      3'd1: p = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      3'd4: p = 64'(sa * sb);
      default: begin
        if (b == 0) p = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  // Issue one op from the current (mid-cycle) time; returns in the cycle after
  // the commit edge (DONE cycle for MULT/DIV, IDLE cycle for MTHI/MTLO).
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
    logic [63:0] r;
    int nb;
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0; src_a = $urandom; src_b = $urandom;
    if (o == 3'd2 || o == 3'd3) begin
      if (o == 3'd2) m_hi = a; else m_lo = a;
      chk("mt_busy", busy, 0);
      chk("mt_done", done, 0);
      chk("mt_hi", hi, m_hi);
      chk("mt_lo", lo, m_lo);
      return;
    end
    r = ref_res(o, a, b);
    nb = 0;
    while (busy === 1'b1 && nb < 200) begin
      if (done !== 1'b0) chk("done_in_run", done, 0);
      if (inject && nb == 3) begin
        start = 1'b1; op = 3'd2; src_a = 32'hDEAD_BEEF;
      end else start = 1'b0;
      // Committed HI/LO must hold during RUN.
      if (nb == 5) chk("run_hold_hi", hi, m_hi);
      nb++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("busy_cycles", nb, ((o[0] && b == 0) ? 0 : W));
    m_hi = r[63:32]; m_lo = r[31:0];
    chk("done_pulse", done, 1);
    chk("res_hi", hi, m_hi);
    chk("res_lo", lo, m_lo);
  endtask

  initial begin
    logic [2:0] o;
    logic [W-1:0] a, b;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);

    run_op(3'd1, 32'd100, 32'd7, 1);   // MTHI injected during RUN must be ignored
    @(posedge clk); #1;
    chk("inj_ignored_hi", hi, m_hi);

    run_op(3'd1, 32'h1234, 32'd0, 0);
    run_op(3'd2, 32'hAAAA0000, 32'd0, 0);
    @(posedge clk); #1;
    chk("mt_no_done", done, 0);

    // Flush at RUN cycle 10 together with a start: flush wins.
    start = 1'b1; op = 3'd0; src_a = 32'd3; src_b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("pre_flush_busy", busy, 1);
    flush = 1'b1; start = 1'b1; op = 3'd0;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    chk("flush_hi", hi, m_hi);
    chk("flush_lo", lo, m_lo);
    @(posedge clk); #1;
    chk("flush_start_dropped", busy, 0);
    chk("flush_no_done", done, 0);

`ifdef MDU_SIGNED_EN
    run_op(3'd4, -32'sd6, 32'd7, 0);
    chk("smul_hi", hi, 32'hFFFFFFFF);
    chk("smul_lo", lo, 32'hFFFFFFD6);
    run_op(3'd5, -32'sd7, 32'd2, 0);
    chk("sdiv_hi", hi, 32'hFFFFFFFF);
    chk("sdiv_lo", lo, 32'hFFFFFFFD);
    run_op(3'd5, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(3'd5, -32'sd9, 32'd0, 0);
`else
    start = 1'b1; op = 3'd4; src_a = 32'd6; src_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    chk("op4_ignored_busy", busy, 0);
    chk("op4_ignored_done", done, 0);
    chk("op4_ignored_lo", lo, m_lo);
`endif
    start = 1'b1; op = 3'd6; src_b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("op6_busy", busy, 0);
    chk("op6_done", done, 0);

    // Random mix, back-to-back issue straight from DONE.
    for (int i = 0; i < 40; i++) begin
`ifdef MDU_SIGNED_EN
      o = 3'($urandom_range(0, 5));
      if (o[2:1] == 2'b10) o = o; else o = {1'b0, o[1:0]};
`else
      o = 3'($urandom_range(0, 3));
`endif
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300)));
      run_op(o, a, b, 0);
      if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
    end

    // Asynchronous reset mid-RUN, between edges.
    start = 1'b1; op = 3'd0; src_a = 32'd123; src_b = 32'd456;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(3'd0, 32'd2, 32'd2, 0);
    chk("post_rst_lo", lo, 4);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
